// File: rtl/maxii_flash_seq_if.sv
// Host-side command/response channel of the MAX-II UFM command sequencer.
// The master modport is the host and the slave modport is the sequencer.
interface maxii_flash_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [8:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/maxii_flash_seq.sv
// Word-level command sequencer in front of the MAX-II UFM access block.
// Turns READ/WRITE/ERASE into byte-serial address/data loads plus a request strobe,
// each step gated on the UFM busy flag and guarded by a saturating busy timeout.
// Optional: define FLASH_SEQ_VERIFY_EN to read back and compare after every WRITE.
module maxii_flash_seq #(
  parameter int unsigned GAP   = 2,
  parameter int unsigned TMO_W = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  maxii_flash_seq_if.slave       host,
  input  logic                   flash_start,
  output logic [7:0]             flash_bus,
  output logic                   flash_load_addr,
  output logic                   flash_load_data,
  output logic                   flash_read_req,
  output logic                   flash_write_req,
  output logic                   flash_erase_req,
  input  logic                   flash_busy,
  input  logic [15:0]            flash_data
);

  localparam int unsigned GapW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [1:0] OpRead  = 2'd0;
  localparam logic [1:0] OpWrite = 2'd1;
  localparam logic [1:0] OpNop   = 2'd3;

  typedef enum logic [3:0] {
    StInit, StIdle, StAhi, StAlo, StDhi, StDlo, StWr, StRd, StEr, StRsp
  } state_e;

  // Sub-phases of one ISSUE step: strobe, post-strobe gap, busy wait.
  typedef enum logic [1:0] {PhIssue, PhGap, PhWait} phase_e;

  state_e           state_q, state_d, step_next;
  phase_e           phase_q, phase_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [TMO_W-1:0] tmo_q, tmo_d, tmo_nxt;
  logic [1:0]       op_q, op_d;
  logic [8:0]       addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [15:0]      rsp_data_q, rsp_data_d;
  logic             err_q, err_d;
  logic             to_init_q, to_init_d;
  logic             vfy_q, vfy_d;
  logic             strobe;

  // Successor of the current ISSUE step once busy has been seen low.
  always_comb begin
    step_next = StRsp;
    case (state_q)
      StAhi: step_next = StAlo;
      StAlo: begin
        if (op_q == OpRead || vfy_q) begin
          step_next = StRd;
        end else if (op_q == OpWrite) begin
          step_next = StDhi;
        end else begin
          step_next = StEr;
        end
      end
      StDhi: step_next = StDlo;
      StDlo: step_next = StWr;
`ifdef FLASH_SEQ_VERIFY_EN
      StWr:  step_next = StAhi;
`else
      StWr:  step_next = StRsp;
`endif
      default: step_next = StRsp;
    endcase
  end

  // Next-state logic: command accept, step sequencing, timeout and start-loss aborts.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    gap_d      = gap_q;
    tmo_d      = tmo_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    err_d      = err_q;
    to_init_d  = to_init_q;
    vfy_d      = vfy_q;
    strobe     = 1'b0;
    tmo_nxt    = (&tmo_q) ? tmo_q : tmo_q + TMO_W'(1);

    case (state_q)
      StInit: begin
        if (flash_start && !flash_busy) state_d = StIdle;
      end
      StIdle: begin
        // An accepted command still aborts cleanly if start has dropped.
        if (host.cmd_valid) begin
          op_d    = host.cmd_op;
          addr_d  = host.cmd_addr;
          wdata_d = host.cmd_wdata;
          err_d   = 1'b0;
          vfy_d   = 1'b0;
          phase_d = PhIssue;
          state_d = (host.cmd_op == OpNop) ? StRsp : StAhi;
        end else if (!flash_start) begin
          state_d = StInit;
        end
      end
      StRsp: begin
        state_d   = (to_init_q || !flash_start) ? StInit : StIdle;
        to_init_d = 1'b0;
      end
      default: begin
        if (!flash_start) begin
          err_d     = 1'b1;
          to_init_d = 1'b1;
          state_d   = StRsp;
        end else begin
          case (phase_q)
            PhIssue: begin
              if (!flash_busy) begin
                strobe = 1'b1;
                tmo_d  = '0;
                if (GAP == 0) begin
                  phase_d = PhWait;
                end else begin
                  phase_d = PhGap;
                  gap_d   = GapW'(GAP);
                end
              end else begin
                tmo_d = tmo_nxt;
                if (&tmo_nxt) begin
                  err_d   = 1'b1;
                  state_d = StRsp;
                end
              end
            end
            PhGap: begin
              if (gap_q <= GapW'(1)) begin
                phase_d = PhWait;
              end else begin
                gap_d = gap_q - GapW'(1);
              end
            end
            PhWait: begin
              if (!flash_busy) begin
                phase_d = PhIssue;
                state_d = step_next;
                if (state_q == StRd) begin
                  rsp_data_d = flash_data;
                  if (vfy_q && (flash_data != wdata_q)) err_d = 1'b1;
                end
`ifdef FLASH_SEQ_VERIFY_EN
                if (state_q == StWr) vfy_d = 1'b1;
`endif
              end else begin
                tmo_d = tmo_nxt;
                if (&tmo_nxt) begin
                  err_d   = 1'b1;
                  state_d = StRsp;
                end
              end
            end
            default: phase_d = PhIssue;
          endcase
        end
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StInit;
      phase_q    <= PhIssue;
      gap_q      <= '0;
      tmo_q      <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
      to_init_q  <= 1'b0;
      vfy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      gap_q      <= gap_d;
      tmo_q      <= tmo_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
      to_init_q  <= to_init_d;
      vfy_q      <= vfy_d;
    end
  end

  // UFM bus byte and strobe decode; the byte is held for the whole step.
  always_comb begin
    flash_bus       = '0;
    flash_load_addr = 1'b0;
    flash_load_data = 1'b0;
    flash_read_req  = 1'b0;
    flash_write_req = 1'b0;
    flash_erase_req = 1'b0;
    case (state_q)
      StAhi: begin
        flash_bus       = {7'b0, addr_q[8]};
        flash_load_addr = strobe;
      end
      StAlo: begin
        flash_bus       = addr_q[7:0];
        flash_load_addr = strobe;
      end
      StDhi: begin
        flash_bus       = wdata_q[15:8];
        flash_load_data = strobe;
      end
      StDlo: begin
        flash_bus       = wdata_q[7:0];
        flash_load_data = strobe;
      end
      StRd:    flash_read_req  = strobe;
      StWr:    flash_write_req = strobe;
      StEr:    flash_erase_req = strobe;
      default: flash_bus       = '0;
    endcase
  end

  // Host handshake outputs.
  always_comb begin
    host.cmd_ready = (state_q == StIdle);
    host.rsp_valid = (state_q == StRsp);
    host.rsp_data  = rsp_data_q;
    host.rsp_err   = err_q;
  end

endmodule

// File: tb/tb_maxii_flash_seq.sv
// Directed self-checking bench for maxii_flash_seq with a behavioural UFM model.
// A second instance with TMO_W=4 faces a UFM whose busy flag sticks high.
module tb_maxii_flash_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- main instance + UFM model ----------------
  maxii_flash_seq_if hif();
  logic        start_en = 1'b0;
  logic        start_kill = 1'b0;
  logic        flash_start;
  logic [7:0]  f_bus;
  logic        f_la, f_ld, f_rr, f_wr, f_er;
  logic        flash_busy;
  logic [15:0] m_data = '0;

  assign flash_start = start_en && !start_kill;

  maxii_flash_seq dut (
    .clk             (clk),
    .reset           (reset),
    .host            (hif),
    .flash_start     (flash_start),
    .flash_bus       (f_bus),
    .flash_load_addr (f_la),
    .flash_load_data (f_ld),
    .flash_read_req  (f_rr),
    .flash_write_req (f_wr),
    .flash_erase_req (f_er),
    .flash_busy      (flash_busy),
    .flash_data      (m_data)
  );

  logic [15:0] mem [512];
  logic [8:0]  m_addr = '0;
  logic [15:0] m_dreg = '0;
  int          busy_cnt = 0;
  int          wr_busy = 40;
  int          n_rd = 0, n_wr = 0, n_er = 0, viol = 0;
  logic        corrupt = 1'b0;
  logic        kill_mode = 1'b0;
  logic [7:0]  bytes [$];

  assign flash_busy = (busy_cnt != 0);

  initial begin
    for (int i = 0; i < 512; i++) mem[i] <= 16'(i);
    mem[9'h1A5] <= 16'hBEEF;
    mem[9'h100] <= 16'h5555;
    mem[9'h0FF] <= 16'h1111;
  end

  // UFM: 9-bit address shift register, 16-bit data shift register, busy registered.
  always @(posedge clk) begin
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if ((f_la || f_ld || f_rr || f_wr || f_er) && flash_busy) viol <= viol + 1;
    if (f_la) begin
      m_addr <= {m_addr[0], f_bus};
      bytes.push_back(f_bus);
      busy_cnt <= 1;
    end
    if (f_ld) begin
      m_dreg <= {m_dreg[7:0], f_bus};
      bytes.push_back(f_bus);
      busy_cnt <= 1;
    end
    if (f_rr) begin
      m_data <= mem[m_addr] ^ {15'b0, corrupt};
      busy_cnt <= 3;
      n_rd <= n_rd + 1;
      if (kill_mode) start_kill <= 1'b1;
    end
    if (f_wr) begin
      mem[m_addr] <= m_dreg;
      busy_cnt <= wr_busy;
      n_wr <= n_wr + 1;
    end
    if (f_er) begin
      for (int i = 0; i < 256; i++) mem[{m_addr[8], i[7:0]}] <= 16'hFFFF;
      busy_cnt <= 5;
      n_er <= n_er + 1;
    end
    if (!kill_mode) start_kill <= 1'b0;
  end

  // ---------------- timeout instance ----------------
  maxii_flash_seq_if hif2();
  logic        start2 = 1'b1;
  logic [7:0]  f2_bus;
  logic        f2_la, f2_ld, f2_rr, f2_wr, f2_er;
  logic        busy2 = 1'b0;
  logic        busy2_rel = 1'b0;
  logic [15:0] data2 = '0;

  maxii_flash_seq #(.GAP(2), .TMO_W(4)) dut2 (
    .clk             (clk),
    .reset           (reset),
    .host            (hif2),
    .flash_start     (start2),
    .flash_bus       (f2_bus),
    .flash_load_addr (f2_la),
    .flash_load_data (f2_ld),
    .flash_read_req  (f2_rr),
    .flash_write_req (f2_wr),
    .flash_erase_req (f2_er),
    .flash_busy      (busy2),
    .flash_data      (data2)
  );

  // Busy latches high on the first strobe and stays until released.
  always @(posedge clk) begin
    if (busy2_rel) busy2 <= 1'b0;
    else if (f2_la || f2_ld || f2_rr || f2_wr || f2_er) busy2 <= 1'b1;
  end

  // Issue one command on the main instance and observe its response.
  // Indices count negedges after the accepting edge (1 = first one).
  task automatic do_cmd(input logic [1:0] op, input logic [8:0] addr, input logic [15:0] wd,
                        output logic [15:0] rdata, output logic rerr, output int pulses,
                        output logic rdy_in_rsp, output logic rdy_after, output logic tmo,
                        output int t_rsp, output int t_busy);
    int n;
    pulses = 0; tmo = 1'b0; t_rsp = -1; t_busy = -1;
    rdata = 'x; rerr = 1'bx; rdy_in_rsp = 1'bx; rdy_after = 1'bx;
    @(negedge clk);
    hif.cmd_valid = 1'b1; hif.cmd_op = op; hif.cmd_addr = addr; hif.cmd_wdata = wd;
    n = 0;
    while (!hif.cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!hif.cmd_ready) tmo = 1'b1;
    @(negedge clk);
    hif.cmd_valid = 1'b0;
    n = 1;
    while (!hif.rsp_valid && n < 3000) begin
      if (flash_busy) t_busy = n;
      @(negedge clk);
      n++;
    end
    if (!hif.rsp_valid) begin
      tmo = 1'b1;
    end else begin
      pulses = 1; t_rsp = n;
      rdata = hif.rsp_data; rerr = hif.rsp_err; rdy_in_rsp = hif.cmd_ready;
    end
    @(negedge clk);
    rdy_after = hif.cmd_ready;
    if (hif.rsp_valid) pulses++;
  endtask

  logic [15:0] r_data;
  logic        r_err, r_rdy_rsp, r_rdy_after, r_tmo;
  int          r_pulses, r_trsp, r_tbusy;

  task automatic test_reset();
    logic bad;
    @(negedge clk);
    n_cmp++; if (hif.cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", hif.cmd_ready); end
    n_cmp++; if (hif.rsp_valid !== 1'b0 || hif.rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp: got %b%b want 00", hif.rsp_valid, hif.rsp_err); end
    n_cmp++; if (hif.rsp_data !== 16'h0000) begin n_err++; $display("FAIL reset_rdata: got %h want 0000", hif.rsp_data); end
    n_cmp++; if ({f_bus, f_la, f_ld, f_rr, f_wr, f_er} !== 13'h0) begin n_err++; $display("FAIL reset_flash: got %h want 0", {f_bus, f_la, f_ld, f_rr, f_wr, f_er}); end
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (hif.cmd_ready !== 1'b0) bad = 1'b1;
    end
    n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL init_hold: got ready while start low, want none"); end
    start_en = 1'b1;
    #1;
    n_cmp++; if (hif.cmd_ready !== 1'b0) begin n_err++; $display("FAIL init_same_cycle: got %b want 0", hif.cmd_ready); end
    @(negedge clk);
    n_cmp++; if (hif.cmd_ready !== 1'b1) begin n_err++; $display("FAIL init_release: got %b want 1", hif.cmd_ready); end
  endtask

  task automatic test_read();
    int b0, rd0;
    b0 = bytes.size(); rd0 = n_rd;
    do_cmd(2'd0, 9'h1A5, 16'h0000, r_data, r_err, r_pulses, r_rdy_rsp, r_rdy_after, r_tmo, r_trsp, r_tbusy);
    n_cmp++; if (r_tmo !== 1'b0) begin n_err++; $display("FAIL read_timeout: got %b want 0", r_tmo); end
    n_cmp++; if (bytes.size() != b0 + 2 || bytes[b0] !== 8'h01 || bytes[b0+1] !== 8'hA5) begin
      n_err++; $display("FAIL read_addr_bytes: got %0d bytes want 01 A5", bytes.size() - b0); end
    n_cmp++; if (n_rd - rd0 != 1) begin n_err++; $display("FAIL read_req_count: got %0d want 1", n_rd - rd0); end
    n_cmp++; if (r_data !== 16'hBEEF || r_err !== 1'b0) begin n_err++; $display("FAIL read_rsp: got %h/%b want beef/0", r_data, r_err); end
    n_cmp++; if (r_pulses != 1) begin n_err++; $display("FAIL read_pulse: got %0d want 1", r_pulses); end
    n_cmp++; if (r_rdy_rsp !== 1'b0 || r_rdy_after !== 1'b1) begin n_err++; $display("FAIL read_ready: got %b%b want 01", r_rdy_rsp, r_rdy_after); end
  endtask

  task automatic test_write();
    int b0, rd0, wr0;
    b0 = bytes.size(); rd0 = n_rd; wr0 = n_wr;
    do_cmd(2'd1, 9'h003, 16'h1234, r_data, r_err, r_pulses, r_rdy_rsp, r_rdy_after, r_tmo, r_trsp, r_tbusy);
    n_cmp++; if (r_tmo !== 1'b0 || r_pulses != 1) begin n_err++; $display("FAIL write_rsp_seen: got tmo %b pulses %0d want 0/1", r_tmo, r_pulses); end
    n_cmp++; if (bytes.size() < b0 + 4 || bytes[b0] !== 8'h00 || bytes[b0+1] !== 8'h03 ||
                 bytes[b0+2] !== 8'h12 || bytes[b0+3] !== 8'h34) begin
      n_err++; $display("FAIL write_bytes: got %0d bytes want 00 03 12 34", bytes.size() - b0); end
    n_cmp++; if (n_wr - wr0 != 1 || mem[9'h003] !== 16'h1234) begin n_err++; $display("FAIL write_mem: got %0d/%h want 1/1234", n_wr - wr0, mem[9'h003]); end
    n_cmp++; if (viol != 0) begin n_err++; $display("FAIL write_busy_strobe: got %0d want 0", viol); end
    n_cmp++; if (r_err !== 1'b0) begin n_err++; $display("FAIL write_err: got %b want 0", r_err); end
`ifdef FLASH_SEQ_VERIFY_EN
    n_cmp++; if (n_rd - rd0 != 1 || r_data !== 16'h1234) begin n_err++; $display("FAIL write_verify: got %0d/%h want 1/1234", n_rd - rd0, r_data); end
`else
    n_cmp++; if (n_rd - rd0 != 0 || r_data !== 16'hBEEF) begin n_err++; $display("FAIL write_rdata: got %0d/%h want 0/beef", n_rd - rd0, r_data); end
    n_cmp++; if (r_trsp != r_tbusy + 2) begin n_err++; $display("FAIL write_latency: got %0d want %0d", r_trsp, r_tbusy + 2); end
`endif
  endtask

  task automatic test_erase();
    int b0, er0;
    b0 = bytes.size(); er0 = n_er;
    do_cmd(2'd2, 9'h100, 16'h0000, r_data, r_err, r_pulses, r_rdy_rsp, r_rdy_after, r_tmo, r_trsp, r_tbusy);
    n_cmp++; if (r_tmo !== 1'b0 || r_err !== 1'b0) begin n_err++; $display("FAIL erase_rsp: got tmo %b err %b want 0/0", r_tmo, r_err); end
    n_cmp++; if (bytes.size() != b0 + 2 || bytes[b0] !== 8'h01 || bytes[b0+1] !== 8'h00) begin
      n_err++; $display("FAIL erase_bytes: got %0d bytes want 01 00", bytes.size() - b0); end
    n_cmp++; if (n_er - er0 != 1) begin n_err++; $display("FAIL erase_count: got %0d want 1", n_er - er0); end
    n_cmp++; if (mem[9'h100] !== 16'hFFFF || mem[9'h1FF] !== 16'hFFFF) begin n_err++; $display("FAIL erase_sector: got %h %h want ffff ffff", mem[9'h100], mem[9'h1FF]); end
    n_cmp++; if (mem[9'h0FF] !== 16'h1111) begin n_err++; $display("FAIL erase_other_sector: got %h want 1111", mem[9'h0FF]); end
  endtask

  task automatic test_nop();
    int b0, rd0;
    b0 = bytes.size(); rd0 = n_rd + n_wr + n_er;
    do_cmd(2'd3, 9'h055, 16'hAAAA, r_data, r_err, r_pulses, r_rdy_rsp, r_rdy_after, r_tmo, r_trsp, r_tbusy);
    n_cmp++; if (r_trsp != 1 || r_err !== 1'b0) begin n_err++; $display("FAIL nop_rsp: got t=%0d err=%b want 1/0", r_trsp, r_err); end
    n_cmp++; if (bytes.size() != b0 || n_rd + n_wr + n_er != rd0) begin n_err++; $display("FAIL nop_activity: got %0d bytes want 0", bytes.size() - b0); end
    n_cmp++; if (r_rdy_after !== 1'b1) begin n_err++; $display("FAIL nop_ready: got %b want 1", r_rdy_after); end
  endtask

  task automatic test_start_loss();
    logic ok;
    kill_mode = 1'b1;
    do_cmd(2'd0, 9'h010, 16'h0000, r_data, r_err, r_pulses, r_rdy_rsp, r_rdy_after, r_tmo, r_trsp, r_tbusy);
    n_cmp++; if (r_tmo !== 1'b0 || r_err !== 1'b1) begin n_err++; $display("FAIL start_loss_err: got tmo %b err %b want 0/1", r_tmo, r_err); end
    n_cmp++; if (r_rdy_after !== 1'b0) begin n_err++; $display("FAIL start_loss_init: got %b want 0", r_rdy_after); end
    kill_mode = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (hif.cmd_ready === 1'b1) ok = 1'b1;
    end
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL start_loss_recover: got %b want 1", ok); end
  endtask

  task automatic test_verify();
    corrupt = 1'b1;
    do_cmd(2'd1, 9'h050, 16'h00FF, r_data, r_err, r_pulses, r_rdy_rsp, r_rdy_after, r_tmo, r_trsp, r_tbusy);
    corrupt = 1'b0;
    n_cmp++; if (r_err !== 1'b1) begin n_err++; $display("FAIL verify_err: got %b want 1", r_err); end
    n_cmp++; if (r_data !== 16'h00FE) begin n_err++; $display("FAIL verify_rdata: got %h want 00fe", r_data); end
  endtask

  task automatic test_timeout();
    int n, s, r, strobes;
    @(negedge clk);
    hif2.cmd_valid = 1'b1; hif2.cmd_op = 2'd0; hif2.cmd_addr = 9'h0AA; hif2.cmd_wdata = '0;
    n = 0;
    while (!hif2.cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    hif2.cmd_valid = 1'b0;
    n = 0; s = -1; r = -1; strobes = 0;
    while (r < 0 && n < 200) begin
      if (f2_la || f2_ld || f2_rr || f2_wr || f2_er) begin strobes++; if (s < 0) s = n; end
      if (hif2.rsp_valid) r = n;
      else begin @(negedge clk); n++; end
    end
    n_cmp++; if (r < 0 || hif2.rsp_err !== 1'b1) begin n_err++; $display("FAIL tmo_err: got t=%0d err=%b want rsp with err 1", r, hif2.rsp_err); end
    n_cmp++; if (r - s != 18) begin n_err++; $display("FAIL tmo_latency: got %0d want 18", r - s); end
    n_cmp++; if (strobes != 1) begin n_err++; $display("FAIL tmo_strobes: got %0d want 1", strobes); end
    @(negedge clk);
    n_cmp++; if (hif2.cmd_ready !== 1'b1 || hif2.rsp_valid !== 1'b0) begin n_err++; $display("FAIL tmo_idle: got %b%b want 10", hif2.cmd_ready, hif2.rsp_valid); end
    busy2_rel = 1'b1;
  endtask

  initial begin
    hif.cmd_valid = 1'b0; hif.cmd_op = '0; hif.cmd_addr = '0; hif.cmd_wdata = '0;
    hif2.cmd_valid = 1'b0; hif2.cmd_op = '0; hif2.cmd_addr = '0; hif2.cmd_wdata = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_erase();
    test_nop();
    test_start_loss();
`ifdef FLASH_SEQ_VERIFY_EN
    test_verify();
`endif
    test_timeout();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
